// File: rtl/fb_scanout.sv
// Framebuffer scan-out: turns a 1280x720 timing stream into reads of a 320x180
// RGB565 framebuffer, expands each word to RGB888 and handles double-buffer swaps.
module fb_scanout #(
  parameter int FB_W       = 320,
  parameter int FB_H       = 180,
  parameter int SCALE_LOG2 = 2,
  parameter int RD_LAT     = 2,
  parameter int ADDR_W     = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              ad_in,
  input  logic              nf_in,
  input  logic              swap_req_in,
  output logic              swap_ack_out,
  output logic              front_buf_out,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] addr_out,
  input  logic [15:0]       rd_data_in,
  output logic [7:0]        red_out,
  output logic [7:0]        green_out,
  output logic [7:0]        blue_out
);

  localparam int                L           = RD_LAT + 2;
  localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] ROW_STEP    = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] ROW_MAX     = ADDR_W'((FB_H - 1) * FB_W);
  localparam logic [10:0]       H_LAST      = 11'((FB_W << SCALE_LOG2) - 1);
  localparam logic [9:0]        V_END       = 10'(FB_H << SCALE_LOG2);

  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] buf_base;
  logic [15:0]       hold;
  logic [RD_LAT-1:0] rd_pipe;
  logic [L-2:0]      ad_pipe;

  logic              fetch;
  logic              row_end;
  logic              capture;
  logic [15:0]       pix;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    fetch    = 1'b0;
    row_end  = 1'b0;
    buf_base = '0;
    capture  = rd_pipe[RD_LAT-1];
    pix      = hold;
    if (front_buf_out) buf_base = FRAME_WORDS;
    if (ad_in && (hcount_in[SCALE_LOG2-1:0] == '0)) fetch = 1'b1;
    if ((hcount_in == H_LAST) && (vcount_in < V_END) && (&vcount_in[SCALE_LOG2-1:0]))
      row_end = 1'b1;
    // Bypass the hold register on the capture cycle so the first pixel of each
    // source column is not a cycle late.
    if (capture) pix = rd_data_in;
  end

  // NOTE: all state, including the delay pipes and hold register, is reset so
  // reads in flight at reset can never be captured or displayed afterwards.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      front_buf_out <= 1'b0;
      swap_ack_out  <= 1'b0;
      row_base      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      swap_ack_out <= 1'b0;
      if (nf_in) begin
        row_base <= '0;
        if (swap_req_in) begin
          front_buf_out <= ~front_buf_out;
          swap_ack_out  <= 1'b1;
        end
      end else if (row_end) begin
        if (row_base < ROW_MAX) row_base <= row_base + ROW_STEP;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_en_out <= 1'b0;
      addr_out  <= '0;
    end else begin
      rd_en_out <= fetch;
      if (fetch)
        addr_out <= buf_base + row_base + ADDR_W'(hcount_in >> SCALE_LOG2);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_pipe <= '0;
      ad_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_en_out;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      ad_pipe[0] <= ad_in;
      for (int i = 1; i < L - 1; i++) ad_pipe[i] <= ad_pipe[i-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hold      <= '0;
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else begin
      if (capture) hold <= rd_data_in;
      // The last stage of the active-draw delay is the output register itself.
      if (ad_pipe[L-2]) begin
        red_out   <= {pix[15:11], pix[15:13]};
        green_out <= {pix[10:5], pix[10:9]};
        blue_out  <= {pix[4:0], pix[4:2]};
      end else begin
        red_out   <= '0;
        green_out <= '0;
        blue_out  <= '0;
      end
    end
  end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameters SHALL be: FB_W, default 320, source columns; FB_H, default 180, source rows; SCALE_LOG2, default 2, upscale shift (4x to 1280x720); RD_LAT, default 2, framebuffer read latency in cycles; ADDR_W, default 17, framebuffer address width.
REQ-002 Ports SHALL be, in order: clk_in in 1, pixel clock; rst_in in 1, reset, asynchronous, active-low; hcount_in in 11, timing column; vcount_in in 10, timing row; ad_in in 1, active draw; nf_in in 1, new-frame pulse; swap_req_in in 1, buffer-swap request level; swap_ack_out out 1, swap acknowledge pulse; front_buf_out out 1, buffer being displayed; rd_en_out out 1, framebuffer read strobe; addr_out out ADDR_W, framebuffer word address; rd_data_in in 16, RGB565 read data; red_out, green_out, blue_out out 8 each, pixel colour.

Function
REQ-003 Buffer b SHALL occupy addresses b*FB_W*FB_H to (b+1)*FB_W*FB_H-1; buf_base = front_buf_out ? FB_W*FB_H : 0.
REQ-004 A row_base register SHALL load 0 on nf_in.
REQ-005 row_base SHALL add FB_W in the cycle hcount_in==1279 when vcount_in<720 and vcount_in[SCALE_LOG2-1:0] is all ones, saturating at (FB_H-1)*FB_W (no wrap).
REQ-006 One cycle after inputs, addr_out SHALL be registered as buf_base + row_base + (hcount_in>>SCALE_LOG2).
REQ-007 rd_en_out SHALL be registered high only for inputs with ad_in=1 and hcount_in[SCALE_LOG2-1:0]==0 (one read per source pixel); addr_out SHALL hold its last value otherwise.
REQ-008 rd_data_in SHALL be valid exactly RD_LAT cycles after rd_en_out=1 and SHALL be captured into a hold register only then; the hold register SHALL keep its value between reads.
REQ-009 Colour expansion SHALL be red={d[15:11],d[15:13]}, green={d[10:5],d[10:9]}, blue={d[4:0],d[4:2]} from the hold register.
REQ-010 Pixel outputs SHALL be registered with total latency L=RD_LAT+2 cycles from hcount_in/vcount_in/ad_in to red/green/blue_out; ad_in SHALL be delayed by L internally.
REQ-011 When the L-delayed ad_in is 0, outputs SHALL be 8'h00 regardless of hold register contents.
REQ-012 Timing columns h..h+3 (h multiple of 4) SHALL all display source column h>>2.
REQ-013 Swap: while swap_req_in=1, on nf_in front_buf_out SHALL toggle and swap_ack_out SHALL pulse high for exactly one cycle, in the same clock edge.
REQ-014 swap_req_in and nf_in asserted in the same cycle SHALL swap at that edge; the new frame's first address SHALL use the new buf_base.
REQ-015 At most one swap SHALL occur per nf_in pulse; swap_req_in held high across two nf_in pulses SHALL produce two swaps and two acks.
REQ-016 swap_req_in deasserted before nf_in SHALL cancel the request with no ack.
REQ-017 front_buf_out SHALL never change except at nf_in.

Reset
REQ-018 rst_in low SHALL asynchronously force front_buf_out=0, swap_ack_out=0, rd_en_out=0, addr_out=0, row_base=0, hold register=0, delay pipes=0, and red/green/blue_out=0.
REQ-019 After rst_in rises, output SHALL stay 0 until L cycles after the first ad_in=1.
REQ-020 Reset mid-frame SHALL discard in-flight reads; data returning after reset SHALL not be captured.

Verification
REQ-021 nf_in then row 0 active; memory word at address 0 = 16'hF800 -> rd_en_out at hcount 0,4,8..; red_out=8'hFF, green_out=0, blue_out=0 at hcount 0..3 appearing 4 cycles late.
REQ-022 vcount_in 3 to 4 transition -> addr_out for vcount 4, hcount 8 = 322; for vcount 719, hcount 1276 = 179*320+319 = 57599.
REQ-023 swap_req_in=1 mid-frame, nf_in pulse -> single swap_ack_out pulse coincident with front_buf_out 0->1; next frame first addr_out = 57600.
REQ-024 swap_req_in and nf_in asserted in the same cycle -> immediate swap and ack; swap_req_in dropped before nf_in -> no ack, front_buf_out unchanged.
REQ-025 ad_in=0 (blanking) with nonzero rd_data_in -> rd_en_out=0, rgb outputs 0.
REQ-026 rst_in low at hcount 600 during reads -> all outputs 0 immediately; returning read data ignored; resumes correctly after next nf_in.
